// File: rtl/axi_addr_window_remap.sv
// AXI4 address window remapper: in-window accesses are forwarded with the window base
// swapped for a target base; out-of-window accesses are answered locally with DECERR.
module axi_addr_window_remap #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    ID_WIDTH        = 4,
  parameter int                    USER_WIDTH      = 1,
  parameter int                    WINDOW_BITS     = 28,
  parameter logic [ADDR_WIDTH-1:0] IN_BASE         = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] TARGET_BASE     = 32'h1000_0000,
  parameter int                    MAX_OUTSTANDING = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  // slave write address
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [USER_WIDTH-1:0]   s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // slave write data / response
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // slave read address / data
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [USER_WIDTH-1:0]   s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // master write address
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic [USER_WIDTH-1:0]   m_axi_awuser,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // master write data / response
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // master read address / data
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [USER_WIDTH-1:0]   m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  // error status
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic                    err_is_write,
  // FSM state observation
  output logic [1:0]              wr_state_dbg,
  output logic                    rd_state_dbg
);

  // Handshake rule on every channel: a transfer happens on a rising clock edge where
  // valid and ready are both high; valid never waits on ready, ready may follow valid.

  typedef enum logic [1:0] {W_PASS = 2'd0, W_SINK = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic {R_PASS = 1'b0, R_ERR = 1'b1} rd_state_t;

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  wr_state_t            wr_state;
  rd_state_t            rd_state;
  logic [CW-1:0]        wr_cnt, rd_cnt;
  logic [7:0]           rd_beat;
  logic [ID_WIDTH-1:0]  err_bid, err_rid;

  logic aw_hit, ar_hit, wr_full, rd_full;
  logic aw_miss_acc, ar_miss_acc;
  logic wr_inc, wr_dec, rd_inc, rd_dec;
  logic [16:0] err_sum;

  assign aw_hit  = s_axi_awaddr[ADDR_WIDTH-1:WINDOW_BITS] == IN_BASE[ADDR_WIDTH-1:WINDOW_BITS];
  assign ar_hit  = s_axi_araddr[ADDR_WIDTH-1:WINDOW_BITS] == IN_BASE[ADDR_WIDTH-1:WINDOW_BITS];
  assign wr_full = wr_cnt == MAX_CNT;
  assign rd_full = rd_cnt == MAX_CNT;

  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = {TARGET_BASE[ADDR_WIDTH-1:WINDOW_BITS], s_axi_awaddr[WINDOW_BITS-1:0]};
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awlock  = s_axi_awlock;
  assign m_axi_awcache = s_axi_awcache;
  assign m_axi_awprot  = s_axi_awprot;
  assign m_axi_awqos   = s_axi_awqos;
  assign m_axi_awuser  = s_axi_awuser;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;

  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = {TARGET_BASE[ADDR_WIDTH-1:WINDOW_BITS], s_axi_araddr[WINDOW_BITS-1:0]};
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign m_axi_arlock  = s_axi_arlock;
  assign m_axi_arcache = s_axi_arcache;
  assign m_axi_arprot  = s_axi_arprot;
  assign m_axi_arqos   = s_axi_arqos;
  assign m_axi_aruser  = s_axi_aruser;

  // Locally generated responses replace the master-side fields only in the error states.
  assign s_axi_bid   = (wr_state == W_RESP) ? err_bid : m_axi_bid;
  assign s_axi_bresp = (wr_state == W_RESP) ? 2'b11 : m_axi_bresp;
  assign s_axi_rid   = (rd_state == R_ERR) ? err_rid : m_axi_rid;
  assign s_axi_rdata = (rd_state == R_ERR) ? '0 : m_axi_rdata;
  assign s_axi_rresp = (rd_state == R_ERR) ? 2'b11 : m_axi_rresp;
  assign s_axi_rlast = (rd_state == R_ERR) ? (rd_beat == 8'd0) : m_axi_rlast;

  assign wr_state_dbg = wr_state;
  assign rd_state_dbg = rd_state;

  always_comb begin
    m_axi_awvalid = 1'b0;
    s_axi_awready = 1'b0;
    m_axi_wvalid  = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    aw_miss_acc   = 1'b0;
    case (wr_state)
      W_PASS: begin
        if (aw_hit) begin
          m_axi_awvalid = s_axi_awvalid && !wr_full;
          s_axi_awready = m_axi_awready && !wr_full;
        end else begin
          // A miss waits for all forwarded writes to drain so its DECERR stays in order.
          s_axi_awready = wr_cnt == '0;
          aw_miss_acc   = s_axi_awvalid && (wr_cnt == '0);
        end
        m_axi_wvalid = s_axi_wvalid;
        s_axi_wready = m_axi_wready;
        s_axi_bvalid = m_axi_bvalid;
        m_axi_bready = s_axi_bready;
      end
      W_SINK:  s_axi_wready = 1'b1;
      W_RESP:  s_axi_bvalid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    m_axi_arvalid = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    m_axi_rready  = 1'b0;
    ar_miss_acc   = 1'b0;
    case (rd_state)
      R_PASS: begin
        if (ar_hit) begin
          m_axi_arvalid = s_axi_arvalid && !rd_full;
          s_axi_arready = m_axi_arready && !rd_full;
        end else begin
          s_axi_arready = rd_cnt == '0;
          ar_miss_acc   = s_axi_arvalid && (rd_cnt == '0);
        end
        s_axi_rvalid = m_axi_rvalid;
        m_axi_rready = s_axi_rready;
      end
      R_ERR:   s_axi_rvalid = 1'b1;
      default: ;
    endcase
  end

  assign wr_inc  = m_axi_awvalid && m_axi_awready;
  assign wr_dec  = m_axi_bvalid && m_axi_bready;
  assign rd_inc  = m_axi_arvalid && m_axi_arready;
  assign rd_dec  = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  assign err_sum = {1'b0, err_count} + {16'd0, aw_miss_acc} + {16'd0, ar_miss_acc};

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state     <= W_PASS;
      rd_state     <= R_PASS;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      rd_beat      <= '0;
      err_bid      <= '0;
      err_rid      <= '0;
      err_count    <= '0;
      err_addr     <= '0;
      err_is_write <= 1'b0;
    end else begin
      case (wr_state)
        W_PASS: if (aw_miss_acc) begin
          err_bid  <= s_axi_awid;
          wr_state <= W_SINK;
        end
        W_SINK: if (s_axi_wvalid && s_axi_wlast) wr_state <= W_RESP;
        W_RESP: if (s_axi_bready) wr_state <= W_PASS;
        default: wr_state <= W_PASS;
      endcase

      case (rd_state)
        R_PASS: if (ar_miss_acc) begin
          err_rid  <= s_axi_arid;
          rd_beat  <= s_axi_arlen;
          rd_state <= R_ERR;
        end
        R_ERR: if (s_axi_rready) begin
          if (rd_beat == 8'd0) rd_state <= R_PASS;
          else                 rd_beat  <= rd_beat - 8'd1;
        end
        default: rd_state <= R_PASS;
      endcase

      case ({wr_inc, wr_dec})
        2'b10:   wr_cnt <= wr_cnt + 1'b1;
        2'b01:   wr_cnt <= wr_cnt - 1'b1;
        default: ;
      endcase
      case ({rd_inc, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: ;
      endcase

      // The write address wins the snapshot when both channels miss together.
      if (aw_miss_acc || ar_miss_acc) begin
        err_count    <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        err_addr     <= aw_miss_acc ? s_axi_awaddr : s_axi_araddr;
        err_is_write <= aw_miss_acc;
      end
    end
  end

endmodule

// File: tb/tb_axi_addr_window_remap.sv
// Directed bench for axi_addr_window_remap: drivers push expected beats into queues,
// negedge monitors pop and compare whenever the DUT completes a handshake.
module tb_axi_addr_window_remap;
  localparam int AW = 32, DW = 64, IW = 4, UW = 1;
  localparam int AR_W = AW + 8 + IW;
  localparam int R_W  = IW + DW + 2 + 1;
  localparam int B_W  = IW + 2;

  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;

  logic [IW-1:0] s_axi_awid = '0, s_axi_arid = '0;
  logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [7:0] s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0] s_axi_awsize = 3'd3, s_axi_arsize = 3'd3, s_axi_awprot = '0, s_axi_arprot = '0;
  logic [1:0] s_axi_awburst = 2'd1, s_axi_arburst = 2'd1;
  logic s_axi_awlock = 1'b0, s_axi_arlock = 1'b0;
  logic [3:0] s_axi_awcache = '0, s_axi_arcache = '0, s_axi_awqos = '0, s_axi_arqos = '0;
  logic [UW-1:0] s_axi_awuser = '0, s_axi_aruser = '0;
  logic s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0, s_axi_awready, s_axi_arready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [DW/8-1:0] s_axi_wstrb = '1;
  logic s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
  logic [IW-1:0] s_axi_bid, s_axi_rid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic s_axi_bvalid, s_axi_bready = 1'b1;
  logic [DW-1:0] s_axi_rdata;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b1;

  logic [IW-1:0] m_axi_awid, m_axi_arid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0] m_axi_awburst, m_axi_arburst;
  logic m_axi_awlock, m_axi_arlock;
  logic [3:0] m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
  logic [UW-1:0] m_axi_awuser, m_axi_aruser;
  logic m_axi_awvalid, m_axi_arvalid, m_axi_awready = 1'b1, m_axi_arready = 1'b1;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b1;
  logic [IW-1:0] m_axi_bid = '0, m_axi_rid = '0;
  logic [1:0] m_axi_bresp = '0, m_axi_rresp = '0;
  logic m_axi_bvalid = 1'b0, m_axi_bready;
  logic [DW-1:0] m_axi_rdata = '0;
  logic m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;
  logic [15:0] err_count;
  logic [AW-1:0] err_addr;
  logic err_is_write;
  logic [1:0] wr_state_dbg;
  logic rd_state_dbg;

  axi_addr_window_remap dut (
    .clock(clock), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awuser(s_axi_awuser), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_aruser(s_axi_aruser), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awuser(m_axi_awuser), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .err_count(err_count), .err_addr(err_addr), .err_is_write(err_is_write),
    .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [AR_W-1:0] exp_ar_q[$], exp_aw_q[$];
  logic [R_W-1:0]  exp_r_q[$];
  logic [B_W-1:0]  exp_b_q[$];
  int n_checks = 0, n_errors = 0;
  int m_aw_seen = 0, m_w_seen = 0, m_w_hs = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (m_axi_awvalid) m_aw_seen++;
      if (m_axi_wvalid) m_w_seen++;
      if (m_axi_wvalid && m_axi_wready) m_w_hs++;
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_ar_q.size() == 0) fail_now("m_ar_unexpected");
        else check("m_ar", 128'({m_axi_araddr, m_axi_arlen, m_axi_arid}), 128'(exp_ar_q.pop_front()));
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_aw_q.size() == 0) fail_now("m_aw_unexpected");
        else check("m_aw", 128'({m_axi_awaddr, m_axi_awlen, m_axi_awid}), 128'(exp_aw_q.pop_front()));
      end
      if (s_axi_rvalid) begin
        if (exp_r_q.size() == 0) begin
          if (s_axi_rready) fail_now("s_r_unexpected");
        end else if (s_axi_rready)
          check("s_r", 128'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}), 128'(exp_r_q.pop_front()));
        else
          check("s_r_stall", 128'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}), 128'(exp_r_q[0]));
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b_q.size() == 0) fail_now("s_b_unexpected");
        else check("s_b", 128'({s_axi_bid, s_axi_bresp}), 128'(exp_b_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_ar(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
    bit ok = 0;
    @(posedge clock); #1;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = id; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (s_axi_arready) begin ok = 1; break; end
    end
    if (!ok) fail_now("ar_accept");
    @(posedge clock); #1 s_axi_arvalid = 1'b0;
  endtask

  task automatic drive_aw(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
    bit ok = 0;
    @(posedge clock); #1;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awid = id; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (s_axi_awready) begin ok = 1; break; end
    end
    if (!ok) fail_now("aw_accept");
    @(posedge clock); #1 s_axi_awvalid = 1'b0;
  endtask

  task automatic master_w(input logic [DW-1:0] data, input logic last);
    bit ok = 0;
    @(posedge clock); #1;
    s_axi_wdata = data; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (s_axi_wready) begin ok = 1; break; end
    end
    if (!ok) fail_now("w_accept");
    @(posedge clock); #1 s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic slave_r(input logic [IW-1:0] id, input logic [DW-1:0] data, input logic last);
    bit ok = 0;
    @(posedge clock); #1;
    m_axi_rid = id; m_axi_rdata = data; m_axi_rresp = 2'b00; m_axi_rlast = last; m_axi_rvalid = 1'b1;
    exp_r_q.push_back({id, data, 2'b00, last});
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (m_axi_rready) begin ok = 1; break; end
    end
    if (!ok) fail_now("m_r_accept");
    @(posedge clock); #1 m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
  endtask

  task automatic slave_b(input logic [IW-1:0] id);
    bit ok = 0;
    @(posedge clock); #1;
    m_axi_bid = id; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b1;
    exp_b_q.push_back({id, 2'b00});
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (m_axi_bready) begin ok = 1; break; end
    end
    if (!ok) fail_now("m_b_accept");
    @(posedge clock); #1 m_axi_bvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int left = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      left = exp_ar_q.size() + exp_aw_q.size() + exp_r_q.size() + exp_b_q.size();
      if (left == 0) break;
    end
    check(name, 128'(left), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int aw_seen0, w_seen0, w_hs0;
    bit ok;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_bvalid", 128'(s_axi_bvalid), 128'(0));
    check("rst_rvalid", 128'(s_axi_rvalid), 128'(0));
    check("rst_err_count", 128'(err_count), 128'(0));
    check("rst_err_addr", 128'(err_addr), 128'(0));
    check("rst_err_is_write", 128'(err_is_write), 128'(0));
    check("rst_wr_state", 128'(wr_state_dbg), 128'(0));
    check("rst_rd_state", 128'(rd_state_dbg), 128'(0));

    // in-window read, zero-latency remap
    exp_ar_q.push_back({32'h1123_4560, 8'd3, 4'd2});
    @(posedge clock); #1;
    s_axi_araddr = 32'h0123_4560; s_axi_arlen = 8'd3; s_axi_arid = 4'd2; s_axi_arvalid = 1'b1;
    #1;
    check("hit_ar_same_cycle", 128'({m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid}),
          128'({1'b1, 32'h1123_4560, 8'd3, 4'd2}));
    @(negedge clock);
    @(posedge clock); #1 s_axi_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) slave_r(4'd2, 64'hD000_0000_0000_0000 + 64'(i), i == 3);
    wait_idle("hit_read_drain");

    // out-of-window write burst is sunk locally
    aw_seen0 = m_aw_seen; w_seen0 = m_w_seen;
    exp_b_q.push_back({4'd7, 2'b11});
    drive_aw(32'h2000_0000, 8'd3, 4'd7);
    for (int i = 0; i < 4; i++) master_w(64'hBEEF_0000 + 64'(i), i == 3);
    wait_idle("miss_write_drain");
    check("miss_w_no_m_aw", 128'(m_aw_seen - aw_seen0), 128'(0));
    check("miss_w_no_m_w", 128'(m_w_seen - w_seen0), 128'(0));
    check("miss_w_err_count", 128'(err_count), 128'(1));
    check("miss_w_err_addr", 128'(err_addr), 128'(32'h2000_0000));
    check("miss_w_err_is_write", 128'(err_is_write), 128'(1));

    // out-of-window read with a toggling rready
    for (int i = 0; i < 8; i++) exp_r_q.push_back({4'd5, 64'd0, 2'b11, i == 7});
    s_axi_rready = 1'b0;
    drive_ar(32'h8000_0040, 8'd7, 4'd5);
    for (int i = 0; i < 60; i++) begin
      if (exp_r_q.size() == 0) break;
      @(posedge clock); #1 s_axi_rready = ~s_axi_rready;
    end
    s_axi_rready = 1'b1;
    wait_idle("miss_read_drain");
    repeat (2) @(negedge clock);
    check("miss_r_back_idle", 128'({s_axi_rvalid, rd_state_dbg}), 128'(0));
    check("miss_r_err_count", 128'(err_count), 128'(2));
    check("miss_r_err_addr", 128'(err_addr), 128'(32'h8000_0040));
    check("miss_r_err_is_write", 128'(err_is_write), 128'(0));

    // miss write held off behind two forwarded writes
    w_hs0 = m_w_hs;
    exp_aw_q.push_back({32'h1000_1000, 8'd0, 4'd1});
    drive_aw(32'h0000_1000, 8'd0, 4'd1);
    master_w(64'h11, 1'b1);
    exp_aw_q.push_back({32'h1000_2000, 8'd0, 4'd3});
    drive_aw(32'h0000_2000, 8'd0, 4'd3);
    master_w(64'h33, 1'b1);
    check("hit_w_forwarded", 128'(m_w_hs - w_hs0), 128'(2));
    @(posedge clock); #1;
    s_axi_awaddr = 32'h3000_0000; s_axi_awlen = 8'd0; s_axi_awid = 4'd9; s_axi_awvalid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("miss_aw_stall_cnt2", 128'({s_axi_awready, m_axi_awvalid}), 128'(0));
    end
    slave_b(4'd1);
    @(negedge clock);
    check("miss_aw_stall_cnt1", 128'(s_axi_awready), 128'(0));
    slave_b(4'd3);
    exp_b_q.push_back({4'd9, 2'b11});
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (s_axi_awready) begin ok = 1; break; end
    end
    if (!ok) fail_now("miss_aw_after_drain");
    @(posedge clock); #1 s_axi_awvalid = 1'b0;
    master_w(64'h99, 1'b1);
    wait_idle("ordered_b_drain");
    check("order_err_count", 128'(err_count), 128'(3));
    check("order_err_addr", 128'(err_addr), 128'(32'h3000_0000));

    // outstanding read limit
    for (int i = 0; i < 8; i++) begin
      exp_ar_q.push_back({32'h1000_0000 | (32'(i) << 8), 8'd0, 4'(i)});
      drive_ar(32'(i) << 8, 8'd0, 4'(i));
    end
    exp_ar_q.push_back({32'h1000_0900, 8'd0, 4'd8});
    @(posedge clock); #1;
    s_axi_araddr = 32'h0000_0900; s_axi_arlen = 8'd0; s_axi_arid = 4'd8; s_axi_arvalid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("ar_full_stall", 128'({s_axi_arready, m_axi_arvalid}), 128'(0));
    end
    slave_r(4'd0, 64'hAA00, 1'b1);
    @(negedge clock);
    check("ar_fwd_next_cycle", 128'({m_axi_arvalid, s_axi_arready}), 128'(2'b11));
    @(posedge clock); #1 s_axi_arvalid = 1'b0;
    for (int i = 1; i < 9; i++) slave_r(4'(i), 64'hAA00 + 64'(i), 1'b1);
    wait_idle("ar_limit_drain");

    // reset in the middle of a DECERR read burst
    for (int i = 0; i < 3; i++) exp_r_q.push_back({4'd4, 64'd0, 2'b11, 1'b0});
    drive_ar(32'h4000_0000, 8'd7, 4'd4);
    repeat (3) @(posedge clock);
    #1 s_axi_rready = 1'b0; reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst_rvalid", 128'(s_axi_rvalid), 128'(0));
    check("mid_rst_rd_state", 128'(rd_state_dbg), 128'(0));
    check("mid_rst_err_count", 128'(err_count), 128'(0));
    check("mid_rst_beats_seen", 128'(exp_r_q.size()), 128'(0));
    @(posedge clock); #1 reset = 1'b0; s_axi_rready = 1'b1;

    // simultaneous write and read misses
    exp_b_q.push_back({4'd1, 2'b11});
    exp_r_q.push_back({4'd2, 64'd0, 2'b11, 1'b1});
    @(posedge clock); #1;
    s_axi_awaddr = 32'h5000_0000; s_axi_awlen = 8'd0; s_axi_awid = 4'd1; s_axi_awvalid = 1'b1;
    s_axi_araddr = 32'h6000_0000; s_axi_arlen = 8'd0; s_axi_arid = 4'd2; s_axi_arvalid = 1'b1;
    @(negedge clock);
    check("dual_miss_ready", 128'({s_axi_awready, s_axi_arready}), 128'(2'b11));
    @(posedge clock); #1 s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    master_w(64'h55, 1'b1);
    wait_idle("dual_miss_drain");
    check("dual_err_count", 128'(err_count), 128'(2));
    check("dual_err_addr", 128'(err_addr), 128'(32'h5000_0000));
    check("dual_err_is_write", 128'(err_is_write), 128'(1));

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi_addr_window_remap.md
Name: axi_addr_window_remap

Overview:
- AXI4 slave-to-master address remapper placed between a core or DMA master port and the board memory/peripheral crossbar.
- Accesses whose upper address bits match a parameterised input window are forwarded with the window base replaced by a target base; all other fields pass through unchanged.
- Accesses outside the window are not forwarded. The block terminates them locally with a DECERR response and records them in error-status registers.
- Per-channel outstanding counters keep locally generated responses ordered behind all forwarded traffic.

Parameters:
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 64, R/W data width; WSTRB width is DATA_WIDTH/8
- ID_WIDTH, 4, AXI ID width
- USER_WIDTH, 1, AWUSER/ARUSER width, passed through
- WINDOW_BITS, 28, number of low offset bits preserved (window size 2^WINDOW_BITS)
- IN_BASE, 32'h0000_0000, input window base; only bits [ADDR_WIDTH-1:WINDOW_BITS] are compared
- TARGET_BASE, 32'h1000_0000, replacement upper bits [ADDR_WIDTH-1:WINDOW_BITS]
- MAX_OUTSTANDING, 8, maximum forwarded transactions in flight per direction (range 1..255)

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- s_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,user,valid}  in  ID_WIDTH,ADDR_WIDTH,8,3,2,1,4,3,4,USER_WIDTH,1  slave write-address channel
- s_axi_awready  out  1  write-address accept
- s_axi_w{data,strb,last,valid}  in  DATA_WIDTH,DATA_WIDTH/8,1,1  slave write data; s_axi_wready out 1
- s_axi_b{id,resp,valid}  out  ID_WIDTH,2,1  write response; s_axi_bready in 1
- s_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,user,valid}  in  same widths as AW  read address; s_axi_arready out 1
- s_axi_r{id,data,resp,last,valid}  out  ID_WIDTH,DATA_WIDTH,2,1,1  read data; s_axi_rready in 1
- m_axi_*  mirror of s_axi_* with opposite directions and identical widths
- err_count  out  16  number of out-of-window accesses, saturating
- err_addr  out  ADDR_WIDTH  address of the most recent out-of-window access
- err_is_write  out  1  1 if that access was a write

Behaviour:
- Hit test (combinational): hit = addr[ADDR_WIDTH-1:WINDOW_BITS] == IN_BASE[ADDR_WIDTH-1:WINDOW_BITS].
- Hit mapping: m_addr = {TARGET_BASE[ADDR_WIDTH-1:WINDOW_BITS], addr[WINDOW_BITS-1:0]}.
- All non-address fields on all channels pass through combinationally when in PASS. Zero added latency for hits.
- Outstanding counters wr_cnt and rd_cnt (width clog2(MAX_OUTSTANDING+1)):
  - wr_cnt increments on m_aw handshake and decrements on m_b handshake; rd_cnt increments on m_ar handshake and decrements on m_r handshake with rlast.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - Hit with cnt == MAX_OUTSTANDING: m_*valid=0 and s_*ready=0 until the counter drops.
- Write FSM states: W_PASS, W_SINK, W_RESP.
  - W_PASS, hit: m_awvalid=s_awvalid, s_awready=m_awready; W and B channels pass through.
  - W_PASS, miss: s_awready=1 only when wr_cnt==0, otherwise stalled with m_awvalid=0. On acceptance, latch awid and go to W_SINK.
  - W_SINK: s_wready=1, m_wvalid=0; sink beats until a beat with wlast handshakes, then go to W_RESP.
  - W_RESP: s_bvalid=1, bresp=2'b11, bid=latched id, m_bready=0; on bready go to W_PASS.
  - In W_SINK and W_RESP, s_awready=0.
- Read FSM states: R_PASS, R_ERR.
  - R_PASS, miss: s_arready=1 only when rd_cnt==0. On acceptance, latch arid, load beat counter with arlen, go to R_ERR.
  - R_ERR: s_rvalid=1, rdata=0, rresp=2'b11, rid=latched id, rlast=(beat counter==0). Decrement on each handshake. Exit to R_PASS after the rlast handshake. s_arready=0 and m_rready=0 in this state.
  - Beat values are held stable while rready=0.
- Error registers update on every miss acceptance.
  - err_count saturates at 16'hFFFF.
  - Simultaneous AW and AR misses: write wins err_addr and err_is_write; err_count increments by 2 (still saturating).
- Read and write paths are independent; either may be in an error state while the other forwards.
- Reset values:
  - Both FSMs return to PASS; counters, beat counter, latched ids, err_count, err_addr and err_is_write are 0.
  - s_bvalid and s_rvalid are driven from the master side, which must also be in reset.
  - Reset mid-error abandons the transaction; no further beats are emitted after the reset cycle.
- A burst that straddles the window boundary is decided on its start address only.

Test Plan:
- AR araddr=0x0123_4560, arlen=3, arid=2 (hit) -> m_araddr=0x1123_4560 in the same cycle, len/id unchanged; 4 R beats pass through with OKAY.
- AW awaddr=0x2000_0000, awlen=3, awid=7 (miss), 4 W beats -> m_awvalid and m_wvalid never assert; bresp=2'b11, bid=7; err_count=1, err_addr=0x2000_0000, err_is_write=1.
- AR miss 0x8000_0040, arlen=7, arid=5, rready toggling every cycle -> exactly 8 beats, rdata=0, rresp=3, rid=5, rlast only on beat 8, values stable while stalled.
- Two hit AWs outstanding (wr_cnt=2), then a miss AW -> s_awready=0 until both m_b handshakes complete; then DECERR B is returned after all forwarded B responses.
- MAX_OUTSTANDING=8: 8 hit ARs without R responses, then a 9th -> s_arready=0; after one rlast handshake the 9th is forwarded in the following cycle.
- reset asserted in R_ERR after beat 3 of 8 -> s_rvalid=0 the next cycle; FSM in R_PASS and err_count=0.
